// File: rtl/xip_flash_arbiter_pkg.sv
// Shared constants, state type and helpers for the XIP flash arbiter.
// Optional build macro: XIP_FAST_READ_EN (fast-read command with a dummy phase).
package xip_pkg;

  localparam logic [7:0] XIP_CMD_READ      = 8'h03;
  localparam logic [7:0] XIP_CMD_FAST_READ = 8'h0B;

  localparam logic [6:0] XIP_CMD_BITS   = 7'd8;
  localparam logic [6:0] XIP_ADDR_BITS  = 7'd24;
  localparam logic [6:0] XIP_DATA_BITS  = 7'd32;
  localparam logic [6:0] XIP_DUMMY_BITS = 7'd8;

`ifdef XIP_FAST_READ_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE, ST_GAP
  } xip_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DONE, ST_GAP
  } xip_state_t;
`endif

  // Flash returns bytes in address order; the first byte received lands in
  // [31:24] of the shift register and belongs in [7:0] of the response.
  function automatic logic [31:0] xip_le_pack(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/xip_flash_arbiter_if.sv
// Requester-side bus for the XIP flash arbiter: two read ports with a
// valid/ready request and a one-cycle response pulse.
interface xip_flash_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_addr;
  logic        rsp0_valid;
  logic [31:0] rsp0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_addr;
  logic        rsp1_valid;
  logic [31:0] rsp1_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/xip_flash_arbiter_spi_shift.sv
// SPI mode-0 bit engine: clock divider, xip_clk generation and a 32-bit
// shift register. Each start runs `width` SCK periods (low half, then high
// half, CLK_DIV cycles each). done is high in the final high cycle of the
// phase so the parent can chain the next phase with no idle cycle.
module xip_spi_shift #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] load,
  input  logic [6:0]  width,
  input  logic        sdi,
  output logic        done,
  output logic        sclk,
  output logic        sdo,
  output logic [31:0] shreg
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic          busy_q;
  logic          half_q;
  logic [DW-1:0] div_q;
  logic [6:0]    bit_q;
  logic          sdi_q;
  logic [31:0]   sh_q;
  logic          div_tc;
  logic          first_high;
  logic          sdi_bit;

  assign div_tc     = (div_q == '0);
  assign first_high = half_q && (div_q == DIV_LOAD);
  // With CLK_DIV=1 the sample cycle is also the shift cycle, so use the pin.
  assign sdi_bit    = first_high ? sdi : sdi_q;
  assign done       = busy_q && half_q && div_tc && (bit_q == 7'd1);
  assign sclk       = half_q;
  // A zero-loaded register keeps sdo low through dummy and data phases.
  assign sdo        = busy_q & sh_q[31];
  assign shreg      = sh_q;

  // Divider, half-period toggle, sdi sampling on the rising cycle, and
  // shift-out on the falling transition so sdo only moves while sclk is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      half_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sdi_q  <= 1'b0;
      sh_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      half_q <= 1'b0;
      div_q  <= DIV_LOAD;
      bit_q  <= width;
      sh_q   <= load;
    end else if (busy_q) begin
      if (first_high) sdi_q <= sdi;
      if (div_tc) begin
        div_q <= DIV_LOAD;
        if (!half_q) begin
          half_q <= 1'b1;
        end else begin
          half_q <= 1'b0;
          sh_q   <= {sh_q[30:0], sdi_bit};
          bit_q  <= bit_q - 7'd1;
          if (bit_q == 7'd1) busy_q <= 1'b0;
        end
      end else begin
        div_q <= div_q - DW'(1);
      end
    end
  end

endmodule

// File: rtl/xip_flash_arbiter.sv
// Round-robin arbiter sharing one XIP SPI flash between an instruction-fetch
// port (0) and a data-read port (1); each grant runs a full 32-bit read.
// Optional build macro: XIP_FAST_READ_EN (command 0x0B plus 8 dummy clocks).
//
// state | meaning
// IDLE  | arbitrate, combinational ready to at most one port
// CMD   | shifting out the 8-bit read command
// ADDR  | shifting out the 24-bit word-aligned address
// DUMMY | 8 dummy clocks (fast-read build only)
// DATA  | shifting in 32 data bits, plus one trailing cycle with sclk low
// DONE  | response pulse to the granted port, chip select released
// GAP   | CS_GAP cycles of chip-select high time before the next grant
module xip_flash_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  xip_flash_arbiter_if.slave        bus,
  output logic                      xip_clk,
  output logic                      xip_cs_n,
  output logic                      xip_sdo,
  input  logic                      xip_sdi
);
  import xip_pkg::*;

`ifdef XIP_FAST_READ_EN
  localparam logic [7:0] CMD = XIP_CMD_FAST_READ;
`else
  localparam logic [7:0] CMD = XIP_CMD_READ;
`endif
  localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);

  xip_state_t  state_q, state_d;
  logic        rr_last_q;
  logic        grant_q;
  logic [23:0] addr_q;
  logic [23:0] sel_addr;
  logic [3:0]  gap_q;
  logic        tail_q;
  logic        cs_n_q;
  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] rsp0_data_q, rsp1_data_q;
  logic        rdy0, rdy1;
  logic        spi_start;
  logic [31:0] spi_load;
  logic [6:0]  spi_width;
  logic        spi_done;
  logic [31:0] spi_rx;

  xip_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (spi_start),
    .load  (spi_load),
    .width (spi_width),
    .sdi   (xip_sdi),
    .done  (spi_done),
    .sclk  (xip_clk),
    .sdo   (xip_sdo),
    .shreg (spi_rx)
  );

  assign sel_addr       = rdy1 ? bus.req1_addr : bus.req0_addr;
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign xip_cs_n       = cs_n_q;

  // Next-state, grant and phase-chaining decode.
  always_comb begin
    state_d   = state_q;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    spi_start = 1'b0;
    spi_load  = '0;
    spi_width = XIP_CMD_BITS;
    case (state_q)
      ST_IDLE: begin
        if (!rst) begin
          rdy0 = bus.req0_valid && (!bus.req1_valid || rr_last_q);
          rdy1 = bus.req1_valid && (!bus.req0_valid || !rr_last_q);
        end
        if (rdy0 || rdy1) begin
          spi_start = 1'b1;
          spi_load  = {CMD, 24'h000000};
          spi_width = XIP_CMD_BITS;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (spi_done) begin
          spi_start = 1'b1;
          spi_load  = {addr_q, 8'h00};
          spi_width = XIP_ADDR_BITS;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (spi_done) begin
          spi_start = 1'b1;
`ifdef XIP_FAST_READ_EN
          spi_width = XIP_DUMMY_BITS;
          state_d   = ST_DUMMY;
`else
          spi_width = XIP_DATA_BITS;
          state_d   = ST_DATA;
`endif
        end
      end
`ifdef XIP_FAST_READ_EN
      ST_DUMMY: begin
        if (spi_done) begin
          spi_start = 1'b1;
          spi_width = XIP_DATA_BITS;
          state_d   = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (tail_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, round-robin pointer, chip select, gap timer and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      gap_q        <= '0;
      tail_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rdy0 || rdy1) begin
        grant_q   <= rdy1;
        rr_last_q <= rdy1;
        addr_q    <= sel_addr & 24'hFFFFFC;
      end
      tail_q <= (state_q == ST_DATA) && spi_done;
      if (state_q == ST_DONE)
        gap_q <= GAP_LOAD;
      else if (state_q == ST_GAP && gap_q != 4'd0)
        gap_q <= gap_q - 4'd1;
      cs_n_q <= (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_GAP);
      rsp0_valid_q <= tail_q && !grant_q;
      rsp1_valid_q <= tail_q && grant_q;
      if (tail_q && !grant_q) rsp0_data_q <= xip_le_pack(spi_rx);
      if (tail_q && grant_q)  rsp1_data_q <= xip_le_pack(spi_rx);
    end
  end

endmodule
